// File: rtl/time_zone_offset_bank_pkg.sv
// Shared types and field widths for the time-zone offset bank.
package tz_pkg;

   localparam int unsigned HOURS_W = 7;
   localparam int unsigned MIN_W   = 6;
   localparam int unsigned OFF_W   = 11;

   localparam logic [2:0] POS_SIGN    = 3'd0;
   localparam logic [2:0] POS_HOURS   = 3'd1;
   localparam logic [2:0] POS_MINUTES = 3'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rep_state_t;

   // One stored offset: sign (1 = plus) and magnitude split into hours/minutes
   typedef struct packed {
      logic               sign;
      logic [HOURS_W-1:0] hours;
      logic [MIN_W-1:0]   minutes;
   } zone_t;

endpackage

// File: rtl/time_zone_offset_bank_if.sv
// Front-panel edit inputs and selected-zone offset outputs of the bank.
interface time_zone_offset_bank_if
   import tz_pkg::*;
#(
   parameter int unsigned NUM_ZONES = 4
);
   localparam int unsigned ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

   logic                     KeyPlus;
   logic                     KeyMinus;
   logic                     EditMode;
   logic [1:0]               screen;
   logic [2:0]               EditPos;
   logic [ZW-1:0]            ZoneSel;
   logic                     TZPlusMinus;
   logic [HOURS_W-1:0]       TZHours;
   logic [MIN_W-1:0]         TZMinutes;
   logic signed [OFF_W-1:0]  TZOffsetMin;
   logic                     Changed;

   modport master (
      output KeyPlus, KeyMinus, EditMode, screen, EditPos, ZoneSel,
      input  TZPlusMinus, TZHours, TZMinutes, TZOffsetMin, Changed
   );

   modport slave (
      input  KeyPlus, KeyMinus, EditMode, screen, EditPos, ZoneSel,
      output TZPlusMinus, TZHours, TZMinutes, TZOffsetMin, Changed
   );

endinterface

// File: rtl/time_zone_offset_bank_key_repeat.sv
// Per-key synchroniser, falling-edge detect and hold-to-repeat step generator.
module key_repeat
   import tz_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY = 500000,
   parameter int unsigned REPEAT_RATE  = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   input  logic enable,
   output logic step
);

   localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

   logic             sync1_q, sync2_q, prev_q;
   logic             held, fall;
   rep_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Flops reset to "pressed" so a key held through reset never looks like a new press
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign held = ~sync2_q;
   assign fall = prev_q & ~sync2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!enable || !held) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (fall) state_d = DELAY;
            end
            DELAY: begin
               if (cnt_q == DELAY_LAST) begin
                  state_d = REPEAT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            REPEAT: begin
               cnt_d = (cnt_q == RATE_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      step = 1'b0;
      if (enable && held) begin
         unique case (state_q)
            IDLE:    step = fall;
            DELAY:   step = (cnt_q == DELAY_LAST);
            REPEAT:  step = (cnt_q == RATE_LAST);
            default: step = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/time_zone_offset_bank.sv
// Bank of time-zone offsets edited by Plus/Minus keys; presents the selected zone.
module time_zone_offset_bank
   import tz_pkg::*;
#(
   parameter int unsigned NUM_ZONES    = 4,
   parameter int unsigned MAX_HOURS    = 14,
   parameter int unsigned MIN_STEP     = 15,
   parameter int unsigned TZ_SCREEN    = 2,
   parameter int unsigned REPEAT_DELAY = 500000,
   parameter int unsigned REPEAT_RATE  = 100000
) (
   input logic                   clk,
   input logic                   reset,
   time_zone_offset_bank_if.slave bus
);

   localparam logic [HOURS_W-1:0] MAX_H   = HOURS_W'(MAX_HOURS);
   localparam logic [MIN_W-1:0]   MSTEP   = MIN_W'(MIN_STEP);
   localparam logic [MIN_W-1:0]   MIN_TOP = MIN_W'(60 - MIN_STEP);

   zone_t            zones_q [NUM_ZONES];
   zone_t            cur, nxt;
   logic             changed_q;
   logic             write;
   logic [1:0]       both_q;
   logic             edit_en, enable;
   logic             plus_step, minus_step, any_step;
   logic [OFF_W-1:0] mag;

   // Both-keys-down detect, aligned with the key synchronisers so it blocks the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) both_q <= 2'b00;
      else       both_q <= {both_q[0], ~bus.KeyPlus & ~bus.KeyMinus};
   end

   assign edit_en = bus.EditMode && (bus.screen == 2'(TZ_SCREEN));
   assign enable  = edit_en && !both_q[1];

   key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_plus (
      .clk    (clk),
      .reset  (reset),
      .key_n  (bus.KeyPlus),
      .enable (enable),
      .step   (plus_step)
   );

   key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_minus (
      .clk    (clk),
      .reset  (reset),
      .key_n  (bus.KeyMinus),
      .enable (enable),
      .step   (minus_step)
   );

   assign any_step = plus_step || minus_step;

   // Step arithmetic on the selected zone, with saturation and zero-sign normalisation
   always_comb begin
      cur = zones_q[bus.ZoneSel];
      nxt = cur;
      if (any_step) begin
         unique case (bus.EditPos)
            POS_SIGN: begin
               if (cur.hours != '0 || cur.minutes != '0) nxt.sign = ~cur.sign;
            end
            POS_HOURS: begin
               if (plus_step) begin
                  if (cur.hours < MAX_H) begin
                     nxt.hours = cur.hours + HOURS_W'(1);
                     if (cur.hours + HOURS_W'(1) == MAX_H) nxt.minutes = '0;
                  end
               end else if (cur.hours != '0) begin
                  nxt.hours = cur.hours - HOURS_W'(1);
               end
            end
            POS_MINUTES: begin
               if (cur.hours == MAX_H)   nxt.minutes = '0;
               else if (plus_step)       nxt.minutes = (cur.minutes >= MIN_TOP) ? '0 : cur.minutes + MSTEP;
               else                      nxt.minutes = (cur.minutes < MSTEP) ? MIN_TOP : cur.minutes - MSTEP;
            end
            default: ;
         endcase
         if (nxt.hours == '0 && nxt.minutes == '0) nxt.sign = 1'b1;
      end
   end

   assign write = any_step && (nxt != cur);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_ZONES); i++) begin
            zones_q[i] <= '{sign: 1'b1, hours: '0, minutes: '0};
         end
         changed_q <= 1'b0;
      end else begin
         changed_q <= write;
         if (write) zones_q[bus.ZoneSel] <= nxt;
      end
   end

   assign mag = OFF_W'(cur.hours) * OFF_W'(60) + OFF_W'(cur.minutes);

   assign bus.TZPlusMinus = cur.sign;
   assign bus.TZHours     = cur.hours;
   assign bus.TZMinutes   = cur.minutes;
   assign bus.TZOffsetMin = cur.sign ? $signed(mag) : -$signed(mag);
   assign bus.Changed     = changed_q;

endmodule
